// File: rtl/parity_frame_receiver.sv
// Serial parity-framed word receiver: deserialises WIDTH data bits (LSB first) plus one
// parity bit, checks parity and publishes the word with reduction flags and counters.
module parity_frame_receiver #(
  parameter int WIDTH = 4,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             all_ones,
  output logic             all_zeros,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             all_ones_q, all_ones_d;
  logic             all_zeros_q, all_zeros_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             expected_parity;
  logic             perr;

  assign expected_parity = (^shift_q) ^ ODD;
  assign perr            = (bit_in != expected_parity);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    all_ones_d   = all_ones_q;
    all_zeros_d  = all_zeros_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    // start with a valid bit always (re)begins a frame, abandoning any partial one
    if (bit_valid && start) begin
      shift_d    = '0;
      shift_d[0] = bit_in;
      idx_d      = IW'(1);
      state_d    = (WIDTH == 1) ? PARITY : DATA;
    end else if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        DATA: begin
          shift_d[idx_q] = bit_in;
          if (idx_q == IW'(WIDTH - 1)) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        PARITY: begin
          data_out_d   = shift_q;
          parity_err_d = perr;
          all_ones_d   = &shift_q;
          all_zeros_d  = ~|shift_q;
          data_valid_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          if (perr && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          idx_d   = '0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      all_ones_q   <= 1'b0;
      all_zeros_q  <= 1'b0;
      frame_cnt_q  <= 8'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      all_ones_q   <= all_ones_d;
      all_zeros_q  <= all_zeros_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign all_ones   = all_ones_q;
  assign all_zeros  = all_zeros_q;
  assign busy       = (state_q != IDLE);
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed self-checking bench for parity_frame_receiver (WIDTH=4, even parity).
module tb_parity_frame_receiver;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       start;
  logic [3:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       all_ones;
  logic       all_zeros;
  logic       busy;
  logic [7:0] frame_cnt;
  logic [7:0] err_cnt;

  int checkCount;
  int failCount;
  int pulseCount;
  int pulseBefore;

  parity_frame_receiver #(.WIDTH(4), .ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .start      (start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .all_ones   (all_ones),
    .all_zeros  (all_zeros),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each clock edge where data_valid is already high counts one cycle of pulse
  always @(posedge clk) begin
    if (data_valid === 1'b1) pulseCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic st);
    @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
    start     = st;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  // d holds the word; d[0] is sent first. gapBase>=0 inserts (gapBase+i)%4 idle cycles
  task automatic sendFrame(input logic [3:0] d, input logic p, input int gapBase);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(d[i], i == 0);
      if (gapBase >= 0) idleCycles((gapBase + i) % 4);
    end
    applyStimulus(p, 1'b0);
  endtask

  task automatic checkFrame(input string tag, input logic [3:0] d, input logic perr,
                            input logic ones, input logic zeros);
    checkOutput({tag, "_dv"}, data_valid, 1'b1);
    checkOutput({tag, "_data"}, data_out, d);
    checkOutput({tag, "_perr"}, parity_err, perr);
    checkOutput({tag, "_ones"}, all_ones, ones);
    checkOutput({tag, "_zeros"}, all_zeros, zeros);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    pulseCount = 0;
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    start      = 1'b0;
    idleCycles(3);
    #1;
    rst = 1'b0;

    checkOutput("rst_data", data_out, 4'h0);
    checkOutput("rst_dv", data_valid, 1'b0);
    checkOutput("rst_perr", parity_err, 1'b0);
    checkOutput("rst_ones", all_ones, 1'b0);
    checkOutput("rst_zeros", all_zeros, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_fcnt", frame_cnt, 8'd0);
    checkOutput("rst_ecnt", err_cnt, 8'd0);

    // Bits 1,0,1,0 then even parity 0
    applyStimulus(1'b1, 1'b1);
    checkOutput("t1_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_dv_early", data_valid, 1'b0);
    checkOutput("t1_busy_par", busy, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkFrame("t1", 4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_fcnt", frame_cnt, 8'd1);
    checkOutput("t1_busy_done", busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("t1_dv_drop", data_valid, 1'b0);
    checkOutput("t1_hold", data_out, 4'b0101);

    sendFrame(4'b1111, 1'b0, -1);
    checkFrame("t2a", 4'b1111, 1'b0, 1'b1, 1'b0);
    sendFrame(4'b0111, 1'b0, -1);
    checkFrame("t2b", 4'b0111, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_ecnt", err_cnt, 8'd1);
    checkOutput("t2_fcnt", frame_cnt, 8'd3);

    sendFrame(4'b0000, 1'b0, -1);
    checkFrame("t3a", 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      sendFrame(4'b0000, 1'b0, g);
      checkFrame("t3gap", 4'b0000, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t3_fcnt", frame_cnt, 8'd8);
    checkOutput("t3_ecnt", err_cnt, 8'd1);

    // A stray data bit after a completed frame leaves the outputs alone
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_stray_data", data_out, 4'b0000);
    checkOutput("t3_stray_busy", busy, 1'b0);

    pulseBefore = pulseCount;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    sendFrame(4'b0111, 1'b1, -1);
    checkFrame("t4", 4'b0111, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_fcnt", frame_cnt, 8'd9);
    checkOutput("t4_ecnt", err_cnt, 8'd1);
    idleCycles(2);
    checkOutput("t4_pulses", pulseCount - pulseBefore, 32'd1);

    pulseBefore = pulseCount;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    doReset();
    checkOutput("t5_data", data_out, 4'h0);
    checkOutput("t5_fcnt", frame_cnt, 8'd0);
    checkOutput("t5_ecnt", err_cnt, 8'd0);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_ones", all_ones, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    idleCycles(2);
    checkOutput("t5_pulses", pulseCount - pulseBefore, 32'd0);
    sendFrame(4'b0110, 1'b0, -1);
    checkFrame("t5", 4'b0110, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_fcnt_after", frame_cnt, 8'd1);

    doReset();
    for (int i = 0; i < 255; i++) sendFrame(4'b0011, 1'b0, -1);
    checkOutput("t6_fcnt255", frame_cnt, 8'd255);
    sendFrame(4'b0011, 1'b0, -1);
    checkOutput("t6_fcnt_wrap", frame_cnt, 8'd0);
    checkOutput("t6_ecnt_good", err_cnt, 8'd0);
    for (int i = 0; i < 300; i++) sendFrame(4'b0001, 1'b0, -1);
    checkOutput("t6_ecnt_sat", err_cnt, 8'd255);
    checkOutput("t6_fcnt300", frame_cnt, 8'd44);
    checkOutput("t6_perr", parity_err, 1'b1);

    idleCycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
